// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured parallel frame out MSB first, repeating it a
// programmed number of times with an optional run of idle-low cycles between frames.
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_cnt_i,
  input  logic [GAP_W-1:0] gap_cnt_i,
  input  logic             abort_i,
  output logic             out_bit_o,
  output logic             out_valid_o,
  output logic             frame_start_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] frames_sent_o
);

  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

  state_e state_q, state_d;

  // Shadow copies of the request, frozen for the whole transmission.
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [GAP_W-1:0] gap_ctr_q, gap_ctr_d;
  logic [CNT_W-1:0] frames_q, frames_d, frames_inc;

  logic out_bit_q, out_bit_d;
  logic out_valid_q, out_valid_d;
  logic frame_start_q, frame_start_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic             load;
  logic [WIDTH-1:0] load_pat;

  assign frames_inc = (frames_q == '1) ? frames_q : frames_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    rep_d         = rep_q;
    gap_d         = gap_q;
    shift_d       = shift_q;
    bit_d         = bit_q;
    gap_ctr_d     = gap_ctr_q;
    frames_d      = frames_q;
    out_bit_d     = 1'b0;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    load          = 1'b0;
    load_pat      = pat_q;

    if (abort_i) begin
      // Drop everything; frames_sent keeps its count and all other outputs clear.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            pat_d    = pattern_i;
            rep_d    = repeat_cnt_i;
            gap_d    = gap_cnt_i;
            frames_d = '0;
            busy_d   = 1'b1;
            if (repeat_cnt_i != '0) begin
              state_d  = StShift;
              load     = 1'b1;
              load_pat = pattern_i;
            end else begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end

        StShift: begin
          busy_d = 1'b1;
          if (bit_q == LastBit) begin
            frames_d = frames_inc;
            if (frames_inc < rep_q) begin
              if (gap_q != '0) begin
                state_d   = StGap;
                gap_ctr_d = gap_q - GAP_W'(1);
              end else begin
                load = 1'b1;
              end
            end else begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end else begin
            out_bit_d   = shift_q[WIDTH-1];
            out_valid_d = 1'b1;
            shift_d     = shift_q << 1;
            bit_d       = bit_q + BitW'(1);
          end
        end

        StGap: begin
          busy_d = 1'b1;
          if (gap_ctr_q == '0) begin
            state_d = StShift;
            load    = 1'b1;
          end else begin
            gap_ctr_d = gap_ctr_q - GAP_W'(1);
          end
        end

        StDone: begin
          state_d = StIdle;
        end

        default: begin
          state_d = StIdle;
        end
      endcase

      // First bit of a frame goes out straight from the pattern; the rest queue in shift_q.
      if (load) begin
        out_bit_d     = load_pat[WIDTH-1];
        out_valid_d   = 1'b1;
        frame_start_d = 1'b1;
        shift_d       = load_pat << 1;
        bit_d         = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pat_q         <= '0;
      rep_q         <= '0;
      gap_q         <= '0;
      shift_q       <= '0;
      bit_q         <= '0;
      gap_ctr_q     <= '0;
      frames_q      <= '0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      rep_q         <= rep_d;
      gap_q         <= gap_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      gap_ctr_q     <= gap_ctr_d;
      frames_q      <= frames_d;
      out_bit_q     <= out_bit_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign out_bit_o     = out_bit_q;
  assign out_valid_o   = out_valid_q;
  assign frame_start_o = frame_start_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign frames_sent_o = frames_q;

endmodule
